// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited in-order
// requests to instruction memory and feeds the IF/ID register from a prefetch FIFO.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        load_stall_i,
  input  logic        branching_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] fetched_instruction_if_o,
  output logic [31:0] pc_if_o,
  output logic        instr_valid_if_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] IF_RESET_PC  = 32'hFFFF_FFFC;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_next;
  logic [31:0]   target_aligned;
  logic          grant;
  logic          accept;
  logic          load;
  logic          take_head;
  logic          bypass;
  logic          push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit covers words in flight plus words buffered, so the FIFO can never overflow.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_o     = !rst_i && !branching_i && (credit_used < CREDIT_LIMIT);
  assign imem_addr_o    = fetch_pc;
  assign target_aligned = branch_target_i & ~32'd3;

  assign grant            = imem_req_o && imem_gnt_i;
  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid_i);
  assign accept           = imem_rvalid_i && (discard == '0) && !branching_i;
  assign load             = !load_stall_i && !branching_i;
  assign take_head        = load && (fifo_count != '0);
  assign bypass           = load && (fifo_count == '0) && accept;
  assign push             = accept && !bypass;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc                 <= RESET_PC;
      resp_pc                  <= RESET_PC;
      outstanding              <= '0;
      discard                  <= '0;
      fifo_count               <= '0;
      rd_ptr                   <= '0;
      wr_ptr                   <= '0;
      fetched_instruction_if_o <= NOP_INSTR;
      pc_if_o                  <= IF_RESET_PC;
      instr_valid_if_o         <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (branching_i) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc                 <= target_aligned;
        resp_pc                  <= target_aligned;
        discard                  <= outstanding_next;
        fifo_count               <= '0;
        rd_ptr                   <= '0;
        wr_ptr                   <= '0;
        fetched_instruction_if_o <= NOP_INSTR;
        instr_valid_if_o         <= 1'b0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
        if (accept) resp_pc <= resp_pc + 32'd4;
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (take_head) rd_ptr <= ptr_inc(rd_ptr);
        fifo_count <= fifo_count + CW'(push) - CW'(take_head);
        if (take_head) begin
          fetched_instruction_if_o <= fifo_instr[rd_ptr];
          pc_if_o                  <= fifo_pc[rd_ptr];
          instr_valid_if_o         <= 1'b1;
        end else if (bypass) begin
          fetched_instruction_if_o <= imem_rdata_i;
          pc_if_o                  <= resp_pc;
          instr_valid_if_o         <= 1'b1;
        end else if (!load_stall_i) begin
          fetched_instruction_if_o <= NOP_INSTR;
          instr_valid_if_o         <= 1'b0;
        end
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: randomized memory timing, stalls, redirects and
// resets; an in-order reference of fetched words feeds a scoreboard queue.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branching = 1'b0;
  logic        load_stall = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic        instr_valid;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .imem_req_o              (imem_req),
    .imem_addr_o             (imem_addr),
    .imem_gnt_i              (gnt),
    .imem_rvalid_i           (rvalid),
    .imem_rdata_i            (rdata),
    .load_stall_i            (load_stall),
    .branching_i             (branching),
    .branch_target_i         (branch_target),
    .fetched_instruction_if_o(instr_if),
    .pc_if_o                 (pc_if),
    .instr_valid_if_o        (instr_valid)
  );

  // Scoreboard: {pc, instr} of every granted word that should still reach IF/ID.
  logic [63:0] exp_q[$];
  // Memory model: pending responses in grant order; live=0 marks words from an abandoned path.
  logic [31:0] resp_data_q[$];
  int          resp_due_q[$];
  bit          resp_live_q[$];

  logic [31:0] model_pc = RESET_PC;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          tp_window = 1'b0;
  int          tp_bubbles = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives the inputs seen at the next rising edge and checks the request side.
  task automatic drive(input logic r, input logic br, input logic [31:0] tgt,
                       input logic st, input logic g, input int lat);
    int   live_cnt;
    int   fifo_cnt;
    logic exp_req;
    @(negedge clk);
    rst = r; branching = br; branch_target = tgt; load_stall = st; gnt = g;
    live_cnt = 0;
    foreach (resp_live_q[i]) if (resp_live_q[i]) live_cnt++;
    fifo_cnt = exp_q.size() - live_cnt;
    exp_req = !r && !br && ((resp_data_q.size() + fifo_cnt) < DEPTH);
    if (r) begin
      resp_data_q.delete(); resp_due_q.delete(); resp_live_q.delete();
      rvalid = 1'b0;
    end else if (resp_data_q.size() > 0 && resp_due_q[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = resp_data_q.pop_front();
      void'(resp_due_q.pop_front());
      void'(resp_live_q.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    #1;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (r) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (br) begin
      exp_q.delete();
      foreach (resp_live_q[i]) resp_live_q[i] = 1'b0;
      model_pc = tgt & ~32'd3;
    end else if (imem_req) begin
      check("imem_addr", imem_addr, model_pc);
      if (g) begin
        exp_q.push_back({model_pc, mem_word(model_pc)});
        resp_data_q.push_back(mem_word(imem_addr));
        resp_due_q.push_back(cyc + lat);
        resp_live_q.push_back(1'b1);
        model_pc = model_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Monitor: what IF/ID must hold after each edge, from the edge's inputs and the scoreboard.
  logic        m_rst, m_br, m_stall;
  logic [31:0] m_pc = 32'hFFFF_FFFC;
  logic [31:0] m_instr = NOP;
  logic        m_valid = 1'b0;
  logic [63:0] m_entry;

  initial begin
    forever begin
      @(posedge clk);
      m_rst = rst; m_br = branching; m_stall = load_stall;
      #2;
      if (m_rst) begin
        m_pc = 32'hFFFF_FFFC; m_instr = NOP; m_valid = 1'b0;
      end else if (m_br) begin
        m_instr = NOP; m_valid = 1'b0;
      end else if (!m_stall) begin
        if (instr_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL if_id_unexpected: got valid pc %h instr %h, required no pending word (cycle %0d)",
                     pc_if, instr_if, cyc);
            m_instr = NOP; m_valid = 1'b0;
          end else begin
            m_entry = exp_q.pop_front();
            m_pc = m_entry[63:32]; m_instr = m_entry[31:0]; m_valid = 1'b1;
          end
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
      check("if_id_valid", 32'(instr_valid), 32'(m_valid));
      check("if_id_pc", pc_if, m_pc);
      check("if_id_instr", instr_if, m_instr);
      if (tp_window && instr_valid !== 1'b1) tp_bubbles++;
    end
  end

  initial begin
    int n;
    logic [31:0] tgt;
    repeat (3) drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1);
    // Free run with single-cycle memory.
    for (int i = 0; i < 30; i++) begin
      if (i == 4) tp_window = 1'b1;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1);
    end
    tp_window = 1'b0;
    check("throughput_bubbles", 32'(tp_bubbles), 32'd0);
    // Load stall for three cycles while streaming.
    repeat (3) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1);
    repeat (6) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1);
    // Redirect with two slow words in flight and stall high.
    repeat (3) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1);
    repeat (8) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1);
    // Grant withheld for four cycles.
    repeat (4) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
    repeat (6) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1);
    // Variable latency and a redirect that wraps the address space.
    repeat (5) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, $urandom_range(1, 3));
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1);
    repeat (10) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, $urandom_range(1, 3));
    // Reset with words outstanding.
    repeat (3) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 2);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1);
    repeat (6) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1);
    // Random mix.
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, tgt,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, $urandom_range(1, 3));
    end
    // Drain: stop granting and let every pending word reach IF/ID.
    n = 0;
    while ((exp_q.size() > 0 || resp_data_q.size() > 0) && n < 50) begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
      n++;
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
    check("drain_pending_words", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
